// File: rtl/quorum_pkg.sv
// Shared types and helpers for the quorum event tracker: FSM state encoding,
// vote width and the two-or-three qualification used by the vote detector.
package quorum_pkg;

    localparam int VOTE_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ACTIVE    = 2'd2,
        RELEASING = 2'd3
    } quorum_state_t;

    // True when exactly two or exactly three votes are set.
    function automatic logic is_quorum(input logic [3:0] v);
        logic [2:0] n;
        n = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
        return (n == 3'd2) || (n == 3'd3);
    endfunction

endpackage

// File: rtl/quorum_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous switch inputs.
// Both stages clear on the synchronous active-low reset.
module quorum_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/quorum_event_tracker.sv
// Debounces the registered two-or-three vote qualification into a quorum level,
// counts quorum episodes and hands each episode's pattern out over valid/ready.
// Optional macro QUORUM_SYNC_EN adds a 2-flop synchronizer in front of v_q.
module quorum_event_tracker
    import quorum_pkg::*;
#(
    parameter int STABLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [VOTE_W-1:0] votes_i,
    input  logic              clear_i,
    input  logic              evt_ready_i,
    output logic              quorum_o,
    output logic              evt_valid_o,
    output logic [VOTE_W-1:0] evt_pattern_o,
    output logic [CNT_W-1:0]  evt_count_o,
    output logic              overflow_o,
    output quorum_state_t     dbg_state
);

    // Handshake: an event transfers on a rising edge where evt_valid_o and
    // evt_ready_i are both 1; evt_valid_o never depends combinationally on
    // evt_ready_i, and evt_pattern_o holds while evt_valid_o is 1.

    localparam logic [8:0]       STABLE_9   = 9'(STABLE);
    localparam bit               STABLE_ONE = (STABLE == 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [VOTE_W-1:0] votes_s;
    logic [VOTE_W-1:0] v_q;
    logic              raw;

    quorum_state_t state_q, state_d;
    logic [7:0]    run_q, run_d;
    logic [8:0]    run_inc;
    logic          run_done;

    logic ep_start;
    logic accept;
    logic load;
    logic drop;

`ifdef QUORUM_SYNC_EN
    quorum_sync #(
        .W (VOTE_W)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (votes_i),
        .q    (votes_s)
    );
`else
    assign votes_s = votes_i;
`endif

    assign raw      = is_quorum(v_q);
    assign run_inc  = {1'b0, run_q} + 9'd1;
    assign run_done = (run_inc == STABLE_9);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            IDLE: begin
                if (raw) begin
                    if (STABLE_ONE) begin
                        state_d = ACTIVE;
                        run_d   = 8'd0;
                    end else begin
                        state_d = ARMING;
                        run_d   = 8'd1;
                    end
                end
            end
            ARMING: begin
                if (!raw) begin
                    state_d = IDLE;
                    run_d   = 8'd0;
                end else if (run_done) begin
                    state_d = ACTIVE;
                    run_d   = 8'd0;
                end else begin
                    run_d = run_inc[7:0];
                end
            end
            ACTIVE: begin
                if (!raw) begin
                    if (STABLE_ONE) begin
                        state_d = IDLE;
                        run_d   = 8'd0;
                    end else begin
                        state_d = RELEASING;
                        run_d   = 8'd1;
                    end
                end
            end
            RELEASING: begin
                // Re-qualifying here resumes the same episode.
                if (raw) begin
                    state_d = ACTIVE;
                    run_d   = 8'd0;
                end else if (run_done) begin
                    state_d = IDLE;
                    run_d   = 8'd0;
                end else begin
                    run_d = run_inc[7:0];
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = 8'd0;
            end
        endcase
    end

    assign ep_start = (state_d == ACTIVE) && ((state_q == IDLE) || (state_q == ARMING));
    assign accept   = evt_valid_o && evt_ready_i;
    assign load     = ep_start && (!evt_valid_o || evt_ready_i);
    assign drop     = ep_start && !load;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            v_q           <= '0;
            state_q       <= IDLE;
            run_q         <= 8'd0;
            evt_valid_o   <= 1'b0;
            evt_pattern_o <= '0;
            evt_count_o   <= '0;
            overflow_o    <= 1'b0;
        end else begin
            v_q     <= votes_s;
            state_q <= state_d;
            run_q   <= run_d;

            if (load) begin
                evt_pattern_o <= v_q;
                evt_valid_o   <= 1'b1;
            end else if (accept) begin
                evt_valid_o <= 1'b0;
            end

            // Clear takes priority but still counts an episode starting this cycle.
            if (clear_i) begin
                evt_count_o <= ep_start ? CNT_W'(1) : '0;
            end else if (ep_start && (evt_count_o != CNT_MAX)) begin
                evt_count_o <= evt_count_o + CNT_W'(1);
            end

            if (clear_i) begin
                overflow_o <= 1'b0;
            end else if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign quorum_o  = (state_q == ACTIVE) || (state_q == RELEASING);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_quorum_event_tracker.sv
// Directed bench for quorum_event_tracker (STABLE = 4): a per-cycle vector
// table for reset/first episode, then hand sequences for the multi-cycle cases.
module tb_quorum_event_tracker;
    import quorum_pkg::*;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst  = 1'b0;
    logic [3:0] votes = 4'h0;
    logic       clear = 1'b0;
    logic       ready = 1'b0;

    logic          quorum, valid, ovf;
    logic [3:0]    pat;
    logic [7:0]    cnt;
    quorum_state_t st;

    logic          quorum_s, valid_s, ovf_s;
    logic [3:0]    pat_s;
    logic [1:0]    cnt_s;
    quorum_state_t st_s;

    quorum_event_tracker #(.STABLE(4), .CNT_W(8)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .votes_i       (votes),
        .clear_i       (clear),
        .evt_ready_i   (ready),
        .quorum_o      (quorum),
        .evt_valid_o   (valid),
        .evt_pattern_o (pat),
        .evt_count_o   (cnt),
        .overflow_o    (ovf),
        .dbg_state     (st)
    );

    quorum_event_tracker #(.STABLE(4), .CNT_W(2)) dut_s (
        .clk           (clk),
        .nrst          (nrst),
        .votes_i       (votes),
        .clear_i       (clear),
        .evt_ready_i   (ready),
        .quorum_o      (quorum_s),
        .evt_valid_o   (valid_s),
        .evt_pattern_o (pat_s),
        .evt_count_o   (cnt_s),
        .overflow_o    (ovf_s),
        .dbg_state     (st_s)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every accepted event must match the next expected pattern.
    always @(negedge clk) begin
        if (nrst === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_unexpected: got %0h expected no event", pat);
            end else begin
                check("accept_pattern", 32'(pat), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic n, input logic [3:0] v, input logic r, input logic c);
        nrst  = n;
        votes = v;
        ready = r;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] v, input int cycles);
        repeat (cycles) drive(1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic q, input logic vld, input logic [3:0] p,
                              input logic [7:0] c, input logic o, input logic [1:0] s);
        check({tag, ".quorum"},  32'(quorum), 32'(q));
        check({tag, ".valid"},   32'(valid),  32'(vld));
        check({tag, ".pattern"}, 32'(pat),    32'(p));
        check({tag, ".count"},   32'(cnt),    32'(c));
        check({tag, ".overflow"}, 32'(ovf),   32'(o));
        check({tag, ".state"},   32'(st),     32'(s));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       nrst;
        logic [3:0] votes;
        logic       ready;
        logic       clear;
        logic       q;
        logic       valid;
        logic [3:0] pat;
        logic [7:0] cnt;
        logic       ovf;
        logic [1:0] st;
    } vec_t;

    function automatic vec_t mk(input logic n, input logic [3:0] v, input logic r, input logic c,
                                input logic q, input logic vld, input logic [3:0] p,
                                input logic [7:0] cn, input logic o, input logic [1:0] s);
        vec_t t;
        t.nrst = n;  t.votes = v;  t.ready = r; t.clear = c;
        t.q = q;     t.valid = vld; t.pat = p;  t.cnt = cn;
        t.ovf = o;   t.st = s;
        return t;
    endfunction

    vec_t tbl[18];
    logic [3:0] sat_pats[5];
    logic [3:0] nq_pats[3];

    initial begin
        // reset held 3 cycles, then released with no votes
        tbl[0]  = mk(0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, IDLE);
        tbl[1]  = mk(0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, IDLE);
        tbl[2]  = mk(0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, IDLE);
        tbl[3]  = mk(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, IDLE);
        tbl[4]  = mk(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, IDLE);
        // 0110 captured at edge k, episode visible after edge k+4
        tbl[5]  = mk(1, 4'h6, 0, 0, 0, 0, 4'h0, 0, 0, IDLE);
        tbl[6]  = mk(1, 4'h6, 0, 0, 0, 0, 4'h0, 0, 0, ARMING);
        tbl[7]  = mk(1, 4'h6, 0, 0, 0, 0, 4'h0, 0, 0, ARMING);
        tbl[8]  = mk(1, 4'h6, 0, 0, 0, 0, 4'h0, 0, 0, ARMING);
        tbl[9]  = mk(1, 4'h6, 0, 0, 1, 1, 4'h6, 1, 0, ACTIVE);
        tbl[10] = mk(1, 4'h6, 1, 0, 1, 0, 4'h6, 1, 0, ACTIVE);
        tbl[11] = mk(1, 4'h6, 0, 0, 1, 0, 4'h6, 1, 0, ACTIVE);
        // release takes 4 non-qualifying samples
        tbl[12] = mk(1, 4'h0, 0, 0, 1, 0, 4'h6, 1, 0, ACTIVE);
        tbl[13] = mk(1, 4'h0, 0, 0, 1, 0, 4'h6, 1, 0, RELEASING);
        tbl[14] = mk(1, 4'h0, 0, 0, 1, 0, 4'h6, 1, 0, RELEASING);
        tbl[15] = mk(1, 4'h0, 0, 0, 1, 0, 4'h6, 1, 0, RELEASING);
        tbl[16] = mk(1, 4'h0, 0, 0, 0, 0, 4'h6, 1, 0, IDLE);
        tbl[17] = mk(1, 4'h0, 0, 1, 0, 0, 4'h6, 0, 0, IDLE);

        sat_pats[0] = 4'h3; sat_pats[1] = 4'h5; sat_pats[2] = 4'h6;
        sat_pats[3] = 4'h9; sat_pats[4] = 4'hC;
        nq_pats[0]  = 4'hF; nq_pats[1]  = 4'h1; nq_pats[2]  = 4'h0;

        @(posedge clk);
        #1;
        exp_q.push_back(4'h6);
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].nrst, tbl[i].votes, tbl[i].ready, tbl[i].clear);
            check_outs($sformatf("vec%0d", i), tbl[i].q, tbl[i].valid, tbl[i].pat,
                       tbl[i].cnt, tbl[i].ovf, tbl[i].st);
        end

        // non-qualifying patterns never raise quorum
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 10; j++) begin
                drive(1, nq_pats[k], 0, 0);
                check($sformatf("nonq%0d_%0d.quorum", k, j), 32'(quorum), 32'd0);
            end
            check($sformatf("nonq%0d.count", k), 32'(cnt), 32'd0);
        end

        // enter ACTIVE with 1011, accept it, then glitch through 1111
        exp_q.push_back(4'hB);
        hold(4'hB, 4);
        check("glitch_a.arming", 32'(st), 32'(ARMING));
        drive(1, 4'hB, 0, 0);
        check_outs("glitch_a.start", 1, 1, 4'hB, 1, 0, ACTIVE);
        drive(1, 4'hB, 1, 0);
        check("glitch_a.accept_valid", 32'(valid), 32'd0);
        for (int j = 0; j < 3; j++) begin
            drive(1, 4'hF, 0, 0);
            check($sformatf("glitch_a.f%0d.quorum", j), 32'(quorum), 32'd1);
        end
        for (int j = 0; j < 3; j++) begin
            drive(1, 4'hB, 0, 0);
            check($sformatf("glitch_a.b%0d.quorum", j), 32'(quorum), 32'd1);
            check($sformatf("glitch_a.b%0d.count", j), 32'(cnt), 32'd1);
        end
        check("glitch_a.state", 32'(st), 32'(ACTIVE));
        check("glitch_a.valid", 32'(valid), 32'd0);
        hold(4'h0, 6);
        check("glitch_a.release", 32'(st), 32'(IDLE));

        // short qualifying burst from IDLE is rejected
        for (int j = 0; j < 7; j++) begin
            drive(1, (j < 3) ? 4'h3 : 4'h0, 0, 0);
            check($sformatf("glitch_i%0d.quorum", j), 32'(quorum), 32'd0);
        end
        check_outs("glitch_i.end", 0, 0, 4'hB, 1, 0, IDLE);

        // overflow: two episodes with nothing accepted
        drive(1, 4'h0, 0, 1);
        check_outs("ovf.clear", 0, 0, 4'hB, 0, 0, IDLE);
        hold(4'h5, 5);
        check_outs("ovf.first", 1, 1, 4'h5, 1, 0, ACTIVE);
        hold(4'h0, 6);
        hold(4'hC, 5);
        check_outs("ovf.second", 1, 1, 4'h5, 2, 1, ACTIVE);
        hold(4'h0, 6);
        check_outs("ovf.idle", 0, 1, 4'h5, 2, 1, IDLE);
        // clear in the same cycle as a third (dropped) episode start
        hold(4'hA, 4);
        drive(1, 4'hA, 0, 1);
        check_outs("ovf.clear_start", 1, 1, 4'h5, 1, 0, ACTIVE);
        drive(1, 4'hA, 0, 0);
        check_outs("ovf.after_clear", 1, 1, 4'h5, 1, 0, ACTIVE);
        exp_q.push_back(4'h5);
        drive(1, 4'hA, 1, 0);
        check("ovf.accept_valid", 32'(valid), 32'd0);
        hold(4'h0, 6);
        check("ovf.release", 32'(st), 32'(IDLE));

        // saturation of the 2-bit counter over 5 accepted episodes
        drive(1, 4'h0, 0, 1);
        check("sat.clear_cnt", 32'(cnt), 32'd0);
        check("sat.clear_cnt_s", 32'(cnt_s), 32'd0);
        for (int n = 1; n <= 5; n++) begin
            exp_q.push_back(sat_pats[n-1]);
            hold(sat_pats[n-1], 5);
            check($sformatf("sat%0d.count", n), 32'(cnt), 32'(n));
            check($sformatf("sat%0d.count_s", n), 32'(cnt_s), 32'((n > 3) ? 3 : n));
            check($sformatf("sat%0d.pattern", n), 32'(pat), 32'(sat_pats[n-1]));
            check($sformatf("sat%0d.valid", n), 32'(valid), 32'd1);
            drive(1, 4'h0, 1, 0);
            check($sformatf("sat%0d.accepted", n), 32'(valid), 32'd0);
            hold(4'h0, 5);
        end
        check("sat.ovf_s", 32'(ovf_s), 32'd0);

        // leave one event pending, then reset from ARMING
        hold(4'hE, 5);
        check_outs("rst.pending", 1, 1, 4'hE, 6, 0, ACTIVE);
        check("rst.count_s_hold", 32'(cnt_s), 32'd3);
        hold(4'h0, 6);
        hold(4'h6, 3);
        check("rst.arming", 32'(st), 32'(ARMING));
        drive(0, 4'h6, 0, 0);
        check_outs("rst.mid", 0, 0, 4'h0, 0, 0, IDLE);
        check("rst.count_s", 32'(cnt_s), 32'd0);
        check("rst.valid_s", 32'(valid_s), 32'd0);
        check("rst.pattern_s", 32'(pat_s), 32'd0);
        check("rst.quorum_s", 32'(quorum_s), 32'd0);
        drive(1, 4'h0, 0, 0);
        check_outs("rst.after", 0, 0, 4'h0, 0, 0, IDLE);
        check("rst.state_s", 32'(st_s), 32'(IDLE));

        check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/quorum_event_tracker.md
# quorum_event_tracker

Sequential stage downstream of the combinational two-or-three vote detector. It registers a 4-bit vote vector and forms the detector's "two or three bits set" qualification on the registered copy. The qualification is debounced into a stable quorum level, and each new quorum episode is counted. Each episode's vote pattern is handed to the consumer over a valid/ready interface.

## Interface
- STABLE, 4: consecutive qualifying (or non-qualifying) sampled cycles required to change `quorum_o`; legal range 1..255.
- CNT_W, 8: width of the episode counter.

- clk  input  1  sole clock; all state updates on its rising edge.
- nrst  input  1  reset, synchronous, active-low.
- votes_i  input  4  raw vote bits.
- clear_i  input  1  synchronous clear of `evt_count_o` and `overflow_o`.
- evt_ready_i  input  1  consumer accepts the pending event.
- quorum_o  output  1  debounced quorum level.
- evt_valid_o  output  1  event pending.
- evt_pattern_o  output  4  registered vote vector captured at episode start.
- evt_count_o  output  CNT_W  episodes seen, saturating.
- overflow_o  output  1  sticky: an event was dropped because the previous one was unaccepted.

## Operation
- Sampling: `v_q <= votes_i` every cycle. `raw = (popcount(v_q) == 2) || (popcount(v_q) == 3)`; 0, 1 or 4 bits set gives `raw = 0`.
- FSM states: IDLE, ARMING, ACTIVE, RELEASING. Run counter `run` is 8 bits. `quorum_o = 1` in ACTIVE and RELEASING.
- IDLE:
  - `raw = 1` and STABLE = 1 goes to ACTIVE.
  - `raw = 1` otherwise goes to ARMING with `run = 1`.
- ARMING:
  - `raw = 0` goes to IDLE.
  - Otherwise `run++`; when `run + 1 == STABLE`, go to ACTIVE.
- ACTIVE: `raw = 0` goes to IDLE if STABLE = 1; otherwise to RELEASING with `run = 1`.
- RELEASING:
  - `raw = 1` goes to ACTIVE. This is not a new episode.
  - Otherwise `run++`; when `run + 1 == STABLE`, go to IDLE.
- Episode start: any transition into ACTIVE from IDLE or ARMING. A transition from RELEASING is not an episode start.
- On episode start:
  - `evt_count_o` increments, saturating at 2^CNT_W-1.
  - If `!evt_valid_o || evt_ready_i`: `evt_pattern_o <= v_q` and `evt_valid_o <= 1`.
  - Otherwise `overflow_o <= 1`; the pending pattern is kept and the new one is dropped.
- Handshake:
  - `evt_valid_o` drops on `evt_valid_o && evt_ready_i` when no episode starts that cycle.
  - `evt_pattern_o` is stable while `evt_valid_o = 1`.
  - Accept and a new event in the same cycle: the new event loads and `evt_valid_o` stays 1.
- `clear_i`:
  - Next cycle `evt_count_o = 0` and `overflow_o = 0`.
  - Simultaneous episode start gives `evt_count_o = 1`.
  - A simultaneous drop still clears `overflow_o`; clear wins.
  - FSM and handshake are unaffected.
- Reset (`nrst = 0` at an edge) gives:
  - FSM IDLE, `run = 0`, `v_q = 0`.
  - All outputs 0, including any pending event. This applies mid-episode too.

## Timing
- `votes_i` captured at edge k and held qualifying through edge k+STABLE-1: `quorum_o` and `evt_valid_o` rise after edge k+STABLE.
- A single-sample glitch of `votes_i` does not change `quorum_o` for STABLE ≥ 2. It only restarts the run count.
- Release latency is symmetric: STABLE non-qualifying samples.
- `evt_ready_i` is sampled on the same edge as `evt_valid_o`. Acceptance takes effect after that edge; there is no combinational path from ready to valid.
- With QUORUM_SYNC_EN, all of the above latencies grow by 2 cycles.

## Configuration
- Macro `QUORUM_SYNC_EN`.
- Defined: `votes_i` passes through a 2-flop synchronizer before `v_q`, for asynchronous switch inputs. The synchronizer flops reset to 0.
- Undefined: `votes_i` is assumed synchronous to `clk` and feeds `v_q` directly.

## Structure
- Shared package `quorum_pkg` holds:
  - the FSM state enum `quorum_state_t` (IDLE, ARMING, ACTIVE, RELEASING);
  - `VOTE_W = 4`;
  - the function `is_quorum(logic [3:0])` returning the two-or-three qualification.
- Sub-module: `quorum_sync`, a parameterised-width 2-flop synchronizer instantiated only under QUORUM_SYNC_EN.

## Test plan
- Reset check: hold `nrst = 0` for 3 cycles, then release with `votes_i = 4'b0000`. All outputs stay 0 and the FSM stays IDLE.
- Episode (STABLE = 4): hold `votes_i = 4'b0110` from edge k. Then `quorum_o = 1`, `evt_valid_o = 1`, `evt_pattern_o = 4'b0110`, `evt_count_o = 1` after edge k+4. Assert `evt_ready_i` for one cycle; `evt_valid_o` drops.
- Non-qualifying patterns: cycle `votes_i` through 4'b1111, 4'b0001 and 4'b0000 for 10 cycles each. `quorum_o` never rises and `evt_count_o` stays 0.
- Glitch rejection:
  - In ACTIVE, apply `votes_i = 4'b1111` for 3 cycles, then 4'b1011. `quorum_o` stays 1 and `evt_count_o` is unchanged.
  - From IDLE, apply 4'b0011 for 3 cycles, then 4'b0000. `quorum_o` stays 0.
- Overflow and clear: keep `evt_ready_i = 0` and create two separate episodes.
  - Result: `evt_count_o = 2`, `overflow_o = 1`, `evt_pattern_o` equal to the first pattern.
  - Then pulse `clear_i` in the same cycle as a third episode start: `evt_count_o = 1` and `overflow_o = 0`.
- Saturation and mid-episode reset:
  - With CNT_W = 2, create 5 episodes, accepting each. `evt_count_o` holds at 3.
  - Assert `nrst = 0` in ARMING: all outputs return to 0 next cycle.
